// File: rtl/dram_lut_pkg.sv
// Shared types and default sizing for the DRAM LUT playback sequencer.
package dram_lut_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int ADDR_W_DEF     = 24;
   localparam int DATA_W_DEF     = 144;
   localparam int FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/lut_seq_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Pushes while full and pops while empty are ignored; storage is not reset.
module lut_seq_fifo #(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign count_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance on accepted push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
   end

   // Pointer registers; clearing them empties the FIFO.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents are only visible once the pointers say so.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/dram_lut_sequencer.sv
// Walks a DRAM lookup table with in-order read commands and replays the
// returned words as a valid/ready stream. Commands are only issued while
// outstanding reads plus buffered words leave room in the return buffer.
// The tag FIFO (one bit: "this read is table index 0") doubles as the
// in-flight counter, since it holds exactly one entry per outstanding read.
module dram_lut_sequencer
   import dram_lut_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = 0,
   parameter int          ADDR_W     = ADDR_W_DEF,
   parameter int          DATA_W     = DATA_W_DEF,
   parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              user_clk,
   input  logic              user_rst_n,
   input  logic              lut_en,
   input  logic [31:0]       lut_size,
   output logic              dram_cmd_valid,
   output logic [ADDR_W-1:0] dram_cmd_addr,
   input  logic              dram_cmd_ready,
   input  logic              dram_rd_valid,
   input  logic [DATA_W-1:0] dram_rd_data,
   output logic              lut_valid,
   output logic [DATA_W-1:0] lut_data,
   output logic              lut_sof,
   input  logic              lut_ready,
   output logic              busy,
   output logic              size_err,
   output logic              rd_ovf
);

   localparam int CW = $clog2(FIFO_DEPTH);

   state_e      state_q, state_d;
   logic [31:0] idx_q, idx_d;
   logic [31:0] size_q, size_d;
   logic        size_err_q, size_err_d;
   logic        rd_ovf_q, rd_ovf_d;
   logic        pend_q, pend_d;

   logic        tag_empty, tag_full, tag_rdata, tag_pop;
   logic [CW:0] tag_count;
   logic        data_empty, data_full, data_push;
   logic [CW:0] data_count;
   logic [DATA_W:0] data_rdata;

   logic [CW+1:0] credit;
   logic [CW:0]   inflight_next;
   logic          cmd_ok, cmd_acc, last_idx, ovf_set, lut_pop;

   // Credit uses registered occupancies so same-cycle events do not race.
   assign credit        = {1'b0, tag_count} + {1'b0, data_count};
   assign cmd_ok        = lut_en & ~tag_full & (credit < (CW+2)'(FIFO_DEPTH));
   assign dram_cmd_valid = (state_q == RUN) & (pend_q | cmd_ok);
   assign dram_cmd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
   assign cmd_acc       = dram_cmd_valid & dram_cmd_ready;
   assign last_idx      = (idx_q == size_q - 32'd1);

   // A return consumes its tag even if the buffer is full, keeping tags aligned.
   assign tag_pop       = dram_rd_valid & ~tag_empty;
   assign data_push     = tag_pop & ~data_full;
   assign ovf_set       = dram_rd_valid & (tag_empty | data_full);
   assign inflight_next = tag_count + (CW+1)'(cmd_acc) - (CW+1)'(tag_pop);

   assign lut_valid = ~data_empty;
   assign lut_pop   = lut_valid & lut_ready;
   assign {lut_sof, lut_data} = data_empty ? '0 : data_rdata;

   assign busy     = (state_q != IDLE);
   assign size_err = size_err_q;
   assign rd_ovf   = rd_ovf_q;

   lut_seq_fifo #(
      .WIDTH (1),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_fifo (
      .clk_i   (user_clk),
      .rst_ni  (user_rst_n),
      .push_i  (cmd_acc),
      .wdata_i (idx_q == 32'd0),
      .pop_i   (tag_pop),
      .rdata_o (tag_rdata),
      .empty_o (tag_empty),
      .full_o  (tag_full),
      .count_o (tag_count)
   );

   lut_seq_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_data_fifo (
      .clk_i   (user_clk),
      .rst_ni  (user_rst_n),
      .push_i  (data_push),
      .wdata_i ({tag_rdata, dram_rd_data}),
      .pop_i   (lut_pop),
      .rdata_o (data_rdata),
      .empty_o (data_empty),
      .full_o  (data_full),
      .count_o (data_count)
   );

   // Sequencer next state: table walk, size latching, drain and sticky flags.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      size_d     = size_q;
      size_err_d = size_err_q;
      rd_ovf_d   = rd_ovf_q;
      pend_d     = dram_cmd_valid & ~dram_cmd_ready;

      case (state_q)
         IDLE: begin
            if (lut_en) begin
               if (lut_size != 32'd0) begin
                  state_d    = RUN;
                  idx_d      = 32'd0;
                  size_d     = lut_size;
                  size_err_d = 1'b0;
                  rd_ovf_d   = 1'b0;
               end else begin
                  size_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (cmd_acc) begin
               if (last_idx) begin
                  // New sizes only take effect at a table boundary.
                  idx_d  = 32'd0;
                  size_d = lut_size;
                  if (lut_size == 32'd0) begin
                     size_err_d = 1'b1;
                     state_d    = DRAIN;
                  end
               end else begin
                  idx_d = idx_q + 32'd1;
               end
            end
            // A presented command must complete its handshake before draining.
            if (!lut_en && !pend_d) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight_next == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ovf_set) begin
         rd_ovf_d = 1'b1;
      end
   end

   // Control registers.
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 32'd0;
         size_q     <= 32'd0;
         size_err_q <= 1'b0;
         rd_ovf_q   <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         size_q     <= size_d;
         size_err_q <= size_err_d;
         rd_ovf_q   <= rd_ovf_d;
         pend_q     <= pend_d;
      end
   end

endmodule

// File: tb/tb_dram_lut_sequencer.sv
// Bench for dram_lut_sequencer: DRAM latency model, table-walk and output
// stream scoreboard, plus directed scenarios with hand-computed expectations.
module tb_dram_lut_sequencer;

   localparam int          DW   = 144;
   localparam int          AW   = 24;
   localparam int unsigned BASE = 32'h00FF_FFFE;
   localparam int unsigned AMOD = 32'h0100_0000;

   logic          user_clk = 1'b0;
   logic          user_rst_n = 1'b0;
   logic          lut_en = 1'b0;
   logic [31:0]   lut_size = 32'd0;
   logic          dram_cmd_valid;
   logic [AW-1:0] dram_cmd_addr;
   logic          dram_cmd_ready = 1'b1;
   logic          dram_rd_valid = 1'b0;
   logic [DW-1:0] dram_rd_data = '0;
   logic          lut_valid;
   logic [DW-1:0] lut_data;
   logic          lut_sof;
   logic          lut_ready = 1'b1;
   logic          busy, size_err, rd_ovf;

   dram_lut_sequencer #(
      .BASE_ADDR  (BASE),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (16)
   ) dut (
      .user_clk       (user_clk),
      .user_rst_n     (user_rst_n),
      .lut_en         (lut_en),
      .lut_size       (lut_size),
      .dram_cmd_valid (dram_cmd_valid),
      .dram_cmd_addr  (dram_cmd_addr),
      .dram_cmd_ready (dram_cmd_ready),
      .dram_rd_valid  (dram_rd_valid),
      .dram_rd_data   (dram_rd_data),
      .lut_valid      (lut_valid),
      .lut_data       (lut_data),
      .lut_sof        (lut_sof),
      .lut_ready      (lut_ready),
      .busy           (busy),
      .size_err       (size_err),
      .rd_ovf         (rd_ovf)
   );

   always #5 user_clk = ~user_clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic          sof;
      int            due;
      bit            stray;
   } rd_t;

   rd_t           dq[$];
   logic [DW:0]   exp_q[$];
   logic [AW-1:0] log_addr[$];

   int checks = 0, errors = 0;
   int cyc = 0, lat = 3, rdy_mode = 0;
   int acc_cnt = 0, out_cnt = 0, sof_cnt = 0, stray_cnt = 0, lv_cnt = 0;
   int last_ret_cyc = 0, fall_cyc = 0;
   int m_idx = 0, m_size = 0;
   bit m_stop = 1'b1;
   bit pend_q = 1'b0, busy_prev = 1'b0;
   logic [AW-1:0] pend_addr = '0;
   bit ret_sof = 1'b0, ret_stray = 1'b0;

   logic [AW-1:0] exp_basic [7] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001,
                                    24'h000002, 24'hFFFFFE, 24'hFFFFFF};
   int            exp_sc [14]   = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 0, 1, 2};

   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
      return {a ^ 24'hA5C3F0, 96'h0123_4567_89AB_CDEF_0011_2233, a};
   endfunction

   task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge user_clk);
      #1;
   endtask

   task automatic start(input int sz);
      m_idx    = 0;
      m_size   = sz;
      m_stop   = 1'b0;
      lut_size = 32'(sz);
      lut_en   = 1'b1;
   endtask

   task automatic wait_acc(input int tgt);
      int n = 0;
      while (acc_cnt < tgt && n < 2000) begin
         @(posedge user_clk);
         #1;
         n++;
      end
      chk("wait_acc_timeout", acc_cnt >= tgt, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || dq.size() != 0 || exp_q.size() != 0 || lut_valid) && n < 3000) begin
         @(posedge user_clk);
         #1;
         n++;
      end
      chk("wait_idle_timeout", n < 3000, 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_valid"}, dram_cmd_valid, 0);
      chk({tag, "_cmd_addr"}, dram_cmd_addr, AW'(BASE));
      chk({tag, "_lut_valid"}, lut_valid, 0);
      chk({tag, "_lut_sof"}, lut_sof, 0);
      chk({tag, "_lut_data"}, lut_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_size_err"}, size_err, 0);
      chk({tag, "_rd_ovf"}, rd_ovf, 0);
   endtask

   // DRAM model: fixed latency, in-order, unstallable returns; also paces cmd_ready.
   always @(posedge user_clk) begin
      cyc++;
      #1;
      dram_cmd_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
      if (dq.size() != 0 && dq[0].due <= cyc) begin
         dram_rd_valid = 1'b1;
         dram_rd_data  = word_of(dq[0].addr);
         ret_sof       = dq[0].sof;
         ret_stray     = dq[0].stray;
         void'(dq.pop_front());
      end else begin
         dram_rd_valid = 1'b0;
         dram_rd_data  = '0;
         ret_sof       = 1'b0;
         ret_stray     = 1'b0;
      end
   end

   // Scoreboard: table walk order, command hold, and output stream contents.
   always @(negedge user_clk) begin : mon
      logic [AW-1:0] ea;
      logic [DW:0]   e;
      if (!user_rst_n) begin
         pend_q    = 1'b0;
         busy_prev = busy;
      end else begin
         chk("lut_valid", lut_valid, exp_q.size() != 0);
         if (lut_valid) lv_cnt++;
         if (lut_valid && lut_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("lut_word", {lut_sof, lut_data}, e);
            out_cnt++;
            if (lut_sof) sof_cnt++;
         end
         if (dram_rd_valid) begin
            last_ret_cyc = cyc;
            if (ret_stray) stray_cnt++;
            else exp_q.push_back({ret_sof, dram_rd_data});
         end
         if (pend_q) begin
            chk("hold_valid", dram_cmd_valid, 1);
            chk("hold_addr", dram_cmd_addr, pend_addr);
         end
         if (dram_cmd_valid && dram_cmd_ready) begin
            chk("cmd_after_zero", m_stop, 0);
            ea = AW'((BASE + 32'(m_idx)) % AMOD);
            chk("cmd_addr", dram_cmd_addr, ea);
            log_addr.push_back(dram_cmd_addr);
            dq.push_back('{addr: dram_cmd_addr, sof: (m_idx == 0), due: cyc + lat, stray: 1'b0});
            acc_cnt++;
            m_idx++;
            if (m_idx >= m_size) begin
               m_idx  = 0;
               m_size = int'(lut_size);
               if (m_size == 0) m_stop = 1'b1;
            end
         end
         pend_q    = dram_cmd_valid && !dram_cmd_ready;
         pend_addr = dram_cmd_addr;
         if (busy_prev && !busy) fall_cyc = cyc;
         busy_prev = busy;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, o, s, st, lv;

      // Reset values.
      repeat (2) @(posedge user_clk);
      @(negedge user_clk);
      chk_reset_vals("rst");
      @(posedge user_clk);
      #1;
      user_rst_n = 1'b1;
      tick(2);

      // Basic run: size 5, latency 3, consumer always ready.
      lat = 3; lut_ready = 1'b1; rdy_mode = 0;
      b = acc_cnt; o = out_cnt; s = sof_cnt;
      start(5);
      @(negedge user_clk);
      chk("en_busy_n", busy, 0);
      chk("en_valid_n", dram_cmd_valid, 0);
      @(posedge user_clk);
      #1;
      chk("en_busy_n1", busy, 1);
      chk("en_valid_n1", dram_cmd_valid, 1);
      wait_acc(b + 30);
      lut_en = 1'b0;
      wait_idle();
      chk("basic_cmds", acc_cnt - b, 30);
      chk("basic_words", out_cnt - o, 30);
      chk("basic_sof", sof_cnt - s, 6);
      for (int i = 0; i < 7; i++) chk("basic_addr", log_addr[b + i], exp_basic[i]);

      // Backpressure: buffer fills to exactly the depth, one pop frees one credit.
      b = acc_cnt; o = out_cnt;
      lut_ready = 1'b0;
      start(5);
      tick(40);
      chk("bp_cmds16", acc_cnt - b, 16);
      chk("bp_valid_low", dram_cmd_valid, 0);
      lut_ready = 1'b1;
      tick(1);
      lut_ready = 1'b0;
      tick(15);
      chk("bp_cmds17", acc_cnt - b, 17);
      chk("bp_valid_low2", dram_cmd_valid, 0);
      lut_en = 1'b0;
      lut_ready = 1'b1;
      wait_idle();
      chk("bp_words", out_cnt - o, 17);

      // Size change 8 -> 3 at idx 4, with command stalls.
      b = acc_cnt;
      rdy_mode = 1;
      start(8);
      wait_acc(b + 4);
      lut_size = 32'd3;
      wait_acc(b + 14);
      lut_en = 1'b0;
      wait_idle();
      rdy_mode = 0;
      for (int i = 0; i < 14; i++)
         chk("sc_idx", int'((32'(log_addr[b + i]) + AMOD - BASE) % AMOD), exp_sc[i]);

      // Zero size at enable.
      b = acc_cnt;
      m_stop = 1'b1;
      lut_size = 32'd0;
      lut_en = 1'b1;
      tick(3);
      chk("z0_size_err", size_err, 1);
      chk("z0_busy", busy, 0);
      chk("z0_cmds", acc_cnt - b, 0);
      lut_en = 1'b0;
      tick(1);

      // Zero size mid-run: table finishes, then drain to idle.
      b = acc_cnt; o = out_cnt;
      start(4);
      tick(1);
      chk("zm_size_err_clr", size_err, 0);
      wait_acc(b + 2);
      lut_size = 32'd0;
      wait_idle();
      chk("zm_cmds", acc_cnt - b, 4);
      chk("zm_words", out_cnt - o, 4);
      chk("zm_size_err", size_err, 1);
      chk("zm_busy", busy, 0);
      lut_en = 1'b0;
      tick(2);

      // Disable with 4 reads in flight.
      lat = 6;
      b = acc_cnt; o = out_cnt;
      start(20);
      tick(1);
      chk("dis_size_err_clr", size_err, 0);
      wait_acc(b + 4);
      lut_en = 1'b0;
      chk("dis_inflight", dq.size(), 4);
      wait_idle();
      chk("dis_cmds", acc_cnt - b, 4);
      chk("dis_words", out_cnt - o, 4);
      chk("dis_busy_fall", fall_cyc, last_ret_cyc + 1);

      // Reset with 2 reads in flight.
      b = acc_cnt; st = stray_cnt;
      start(10);
      wait_acc(b + 2);
      user_rst_n = 1'b0;
      lut_en = 1'b0;
      for (int i = 0; i < dq.size(); i++) dq[i].stray = 1'b1;
      exp_q.delete();
      m_stop = 1'b1;
      @(negedge user_clk);
      chk_reset_vals("mid_rst");
      @(posedge user_clk);
      #1;
      user_rst_n = 1'b1;
      lv = lv_cnt;
      tick(12);
      chk("rst_strays", stray_cnt - st, 2);
      chk("rst_rd_ovf", rd_ovf, 1);
      chk("rst_no_valid", lv_cnt - lv, 0);
      chk("rst_busy", busy, 0);

      // rd_ovf clears on the next start.
      lat = 3;
      start(2);
      tick(1);
      chk("ovf_clr", rd_ovf, 0);
      lut_en = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dram_lut_sequencer.md
# dram_lut_sequencer

Playback sequencer for the chan_512 DRAM lookup table. It sits in the `user_clk` domain, between the software-written `lut_size` register and the DRAM read-command port. While enabled, it issues in-order read commands that walk the table from `BASE_ADDR` and wrap at `lut_size`. It buffers the returned words and presents them as a valid/ready stream to the DAC/channelizer datapath, using credit-based flow control so the buffer never overflows.

## Interface
- `BASE_ADDR`, 0, DRAM word address of table entry 0.
- `ADDR_W`, 24, DRAM command address width.
- `DATA_W`, 144, DRAM read-data width.
- `FIFO_DEPTH`, 16, read-return buffer depth; power of two, ≥ 4.
- `user_clk` in 1: sole clock.
- `user_rst_n` in 1: asynchronous, active-low reset.
- `lut_en` in 1: level; run while high.
- `lut_size` in 32: table length in DRAM words, already in the `user_clk` domain.
- `dram_cmd_valid` out 1: read command valid.
- `dram_cmd_addr` out `ADDR_W`: read address.
- `dram_cmd_ready` in 1: command accepted when high together with valid.
- `dram_rd_valid` in 1: read data return; returns arrive in order and cannot be stalled.
- `dram_rd_data` in `DATA_W`: read data.
- `lut_valid` out 1: output word available.
- `lut_data` out `DATA_W`: output word.
- `lut_sof` out 1: marks the current output word as table index 0.
- `lut_ready` in 1: consumer accepts the word when high together with valid.
- `busy` out 1: state is not IDLE.
- `size_err` out 1: sticky; a `lut_size` of 0 was sampled.
- `rd_ovf` out 1: sticky; a read return arrived with no matching tag or a full buffer.

## Operation
- **IDLE.**
  - If `lut_en`=1 and `lut_size`≠0: latch the size, set idx=0, go to RUN.
  - If `lut_en`=1 and `lut_size`=0: set `size_err`, stay in IDLE.
  - `size_err` and `rd_ovf` clear only on reset or on an IDLE→RUN transition.
- **RUN.**
  - Define credit = in_flight + data FIFO count.
  - Assert `dram_cmd_valid` when `lut_en`=1 and credit < `FIFO_DEPTH`.
  - `dram_cmd_addr` = `BASE_ADDR` + idx, computed modulo 2^`ADDR_W`.
  - On accept: push tag (idx==0) into the tag FIFO, increment in_flight, and advance idx.
  - On accepting the command with idx = size−1: set idx to 0 and re-latch `lut_size`. If the new value is 0, set `size_err` and go to DRAIN. A new size therefore takes effect only at a table boundary.
  - `lut_en`=0 → DRAIN. A command already presented is held until it is accepted; the transition happens after that handshake.
- **DRAIN.**
  - Issue no new commands.
  - When in_flight = 0, go to IDLE. The data FIFO keeps delivering words to the consumer.
- **Read return.**
  - On `dram_rd_valid`: pop the tag, write {tag, data} into the data FIFO, decrement in_flight.
  - If the tag FIFO is empty or the data FIFO is full: drop the word and set `rd_ovf`.
- **Output.** First-word-fall-through: `lut_valid` = data FIFO not empty; pop on `lut_valid` & `lut_ready`.
- **Simultaneous events.** A command accept and a read return in the same cycle leave in_flight unchanged; the credit accounting uses the registered counts.

## Timing
- Reset values:
  - state = IDLE; idx = 0; in_flight = 0; both FIFOs empty.
  - `dram_cmd_valid` = 0, `dram_cmd_addr` = `BASE_ADDR`.
  - `lut_valid` = 0, `lut_sof` = 0, `lut_data` = 0.
  - `busy` = 0, `size_err` = 0, `rd_ovf` = 0.
- Command path:
  - `lut_en` sampled high in cycle N → `busy` = 1 and `dram_cmd_valid` = 1 in cycle N+1.
  - Back-to-back accepts sustain one command per cycle.
  - `dram_cmd_addr` is stable while valid & !ready.
- Return path: a return written in cycle N → `lut_valid` = 1 in cycle N+1.
- Reset mid-operation: all state clears at once. Read returns still in flight afterwards are dropped and set `rd_ovf`.

## Structure
- Package `dram_lut_pkg`: state enum (IDLE, RUN, DRAIN) and the default constants for `ADDR_W`, `DATA_W`, and `FIFO_DEPTH`.
- Sub-module `lut_seq_fifo`: synchronous FWFT FIFO parameterised by width and depth, with a count output. It is instantiated twice:
  - tag FIFO, width 1;
  - data FIFO, width `DATA_W`+1.

## Test plan
- **Basic run.** Size 5, ready always high, DRAM latency 3:
  - addresses `BASE_ADDR`+0..4 repeating;
  - `lut_sof` on every 5th output word;
  - the output stream equals the table contents in order.
- **Backpressure.** `lut_ready` held low:
  - exactly 16 commands are accepted, then `dram_cmd_valid` stays low;
  - after one pop, exactly one more command is issued.
- **Size change.** Size changed from 8 to 3 at idx 4:
  - idx 5..7 are still issued;
  - the following cycle of commands is 0,1,2.
- **Zero size.**
  - Size 0 with `lut_en`=1 → `size_err`=1, `busy`=0, no commands.
  - Size changed to 0 mid-run → the remainder of the table is issued, then DRAIN → IDLE.
- **Disable mid-run.** `lut_en` dropped with 4 reads in flight:
  - no new commands are issued;
  - `busy` falls one cycle after the 4th return;
  - all 4 words are delivered.
- **Reset mid-run.** `user_rst_n` pulsed with 2 reads in flight:
  - all outputs return to their reset values;
  - both stray returns set `rd_ovf` and produce no `lut_valid`.
